fir_control_unit: RTL

// Control unit that drives the FIR datapath. Accepts coefficient and sample streams
// (valid/ready) and loads coefficients into the datapath. Issues one compute per sample,

---
 rtl/fir_control_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fir_control_unit.sv
// Control unit for the FIR datapath: coefficient load, per-sample compute issue,
// warm-up result dropping and an output FIFO presented as a valid/ready stream.
//
// Handshakes: a beat transfers on the rising clk edge where tvalid && tready are both 1;
// tready never depends on the same-cycle tvalid, and a producer holds tdata stable while
// tvalid is high and tready is low.
module fir_control_unit #(
  parameter int MAX_TAPS       = 16,
  parameter int OUT_DEPTH      = 4,
  parameter int RESULT_TIMEOUT = 64,
  parameter int DROP_WARMUP    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] cfg_tap_count,
  input  logic        cfg_start,
  input  logic [31:0] s_coeff_tdata,
  input  logic        s_coeff_tvalid,
  output logic        s_coeff_tready,
  input  logic [31:0] s_data_tdata,
  input  logic        s_data_tvalid,
  output logic        s_data_tready,
  output logic [31:0] m_data_tdata,
  output logic        m_data_tvalid,
  input  logic        m_data_tready,
  output logic [31:0] dp_tap_count,
  output logic [31:0] dp_coeff_data,
  output logic        dp_coeff_data_valid,
  output logic [31:0] dp_input_data,
  output logic        dp_input_data_valid,
  output logic        dp_compute,
  input  logic [31:0] dp_output_data,
  input  logic        dp_output_data_valid,
  input  logic        dp_coeff_load_complete,
  output logic        busy,
  output logic        err_cfg,
  output logic        err_timeout,
  output logic [2:0]  dbg_state
);

  localparam int TW  = $clog2(MAX_TAPS + 1);
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int PW  = $clog2(OUT_DEPTH);
  localparam int TMW = $clog2(RESULT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_RUN       = 3'd3,
    S_WAIT_RES  = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   beat_q;
  logic [TW-1:0]   warm_q;
  logic [TMW-1:0]  tmr_q;
  logic [31:0]     mem [OUT_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;

  logic [TW-1:0] tap_n;
  logic cfg_ok, coeff_hs, data_hs, tmo, keep, push, pop, push_ok;

  assign tap_n    = dp_tap_count[TW-1:0];
  assign cfg_ok   = (cfg_tap_count != 32'd0) && (cfg_tap_count <= 32'(MAX_TAPS));
  assign coeff_hs = s_coeff_tvalid && s_coeff_tready;
  assign data_hs  = s_data_tvalid && s_data_tready;
  assign tmo      = (tmr_q == TMW'(RESULT_TIMEOUT - 1));
  // warm_q already counts the in-flight sample, so it is its 1-based index
  assign keep     = (DROP_WARMUP == 0) || (warm_q >= tap_n);
  assign push     = (state_q == S_WAIT_RES) && dp_output_data_valid && keep;
  assign pop      = m_data_tvalid && m_data_tready;
  assign push_ok  = push && ((cnt < CW'(OUT_DEPTH)) || pop);

  assign m_data_tvalid = (cnt != '0);
  assign m_data_tdata  = mem[rd_ptr];
  assign busy          = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign dbg_state     = state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    s_coeff_tready = 1'b0;
    s_data_tready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) state_d = cfg_ok ? S_LOAD : S_ERROR;
      end
      S_LOAD: begin
        s_coeff_tready = 1'b1;
        if (coeff_hs && (beat_q == tap_n - TW'(1))) state_d = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        if (dp_coeff_load_complete) state_d = S_RUN;
        else if (tmo)               state_d = S_ERROR;
      end
      S_RUN: begin
        // one FIFO slot stays free for the single result that can be in flight
        s_data_tready = (cnt < CW'(OUT_DEPTH));
        if (data_hs) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (dp_output_data_valid) state_d = S_RUN;
        else if (tmo)             state_d = S_ERROR;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dp_tap_count        <= '0;
      dp_coeff_data       <= '0;
      dp_coeff_data_valid <= 1'b0;
      dp_input_data       <= '0;
      dp_input_data_valid <= 1'b0;
      dp_compute          <= 1'b0;
      beat_q              <= '0;
      warm_q              <= '0;
      tmr_q               <= '0;
      err_cfg             <= 1'b0;
      err_timeout         <= 1'b0;
    end else begin
      dp_coeff_data_valid <= 1'b0;
      dp_input_data_valid <= 1'b0;
      dp_compute          <= 1'b0;
      tmr_q <= ((state_q == S_LOAD_WAIT) || (state_q == S_WAIT_RES)) ? tmr_q + TMW'(1) : '0;
      if ((state_q == S_IDLE) && cfg_start) begin
        if (cfg_ok) begin
          dp_tap_count <= cfg_tap_count;
          beat_q       <= '0;
          warm_q       <= '0;
        end else begin
          err_cfg <= 1'b1;
        end
      end
      if (coeff_hs) begin
        dp_coeff_data       <= s_coeff_tdata;
        dp_coeff_data_valid <= 1'b1;
        beat_q              <= beat_q + TW'(1);
      end
      if (data_hs) begin
        dp_input_data       <= s_data_tdata;
        dp_input_data_valid <= 1'b1;
        dp_compute          <= 1'b1;
        if (warm_q < tap_n) warm_q <= warm_q + TW'(1);
      end
      if (((state_q == S_LOAD_WAIT) || (state_q == S_WAIT_RES)) && (state_d == S_ERROR))
        err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= dp_output_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop);
    end
  end

endmodule
